// File: rtl/comparator_search_ctrl.sv
// Sweeps candidate codes into an equality comparator until it reports a match
// or every code has been probed, then reports the code, a found flag and the probe count.
module comparator_search_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eq,
  output logic [WIDTH-1:0] cand,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   tries
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CAND_MAX = '1;
  localparam logic [WIDTH-1:0] CAND_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   TRIES_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] w_cand_next;
  logic             r_found;
  logic             w_found_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic [WIDTH:0]   r_tries;
  logic [WIDTH:0]   w_tries_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cand   <= '0;
      r_found  <= 1'b0;
      r_result <= '0;
      r_tries  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_found  <= w_found_next;
      r_result <= w_result_next;
      r_tries  <= w_tries_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cand_next   = r_cand;
    w_found_next  = r_found;
    w_result_next = r_result;
    w_tries_next  = r_tries;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cand_next   = '0;
          w_tries_next  = '0;
          w_found_next  = 1'b0;
          w_result_next = '0;
          w_state_next  = S_PROBE;
        end
      end
      S_PROBE: begin
        w_tries_next = r_tries + TRIES_ONE;
        if (eq) begin
          w_result_next = r_cand;
          w_found_next  = 1'b1;
          w_state_next  = S_DONE;
        end else if (r_cand == CAND_MAX) begin
          // Exhausted: cand parks on the last code rather than wrapping.
          w_found_next  = 1'b0;
          w_result_next = '0;
          w_state_next  = S_DONE;
        end else begin
          w_cand_next = r_cand + CAND_ONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign cand   = r_cand;
  assign busy   = (r_state == S_PROBE) || (r_state == S_DONE);
  assign done   = (r_state == S_DONE);
  assign found  = r_found;
  assign result = r_result;
  assign tries  = r_tries;

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Directed bench: a behavioural comparator holds the key; searches are checked
// for candidate sequence, latency, busy/done framing and the held results.
module tb_comparator_search_ctrl;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             eq;
  logic [WIDTH-1:0] cand;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   tries;

  logic [WIDTH-1:0] key = '0;
  logic             kill = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign eq = kill ? 1'b0 : (cand == key);

  comparator_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .eq     (eq),
    .cand   (cand),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .tries  (tries)
  );

  typedef struct {
    int key;
    int kill;
    int exp_found;
    int exp_result;
    int exp_tries;
    int exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called on the falling edge inside the first PROBE cycle (candidate 0 on the bus).
  task automatic probe_track(input string tag, input int exp_lat, input int exp_found,
                             input int exp_result, input int exp_cand);
    int lat = 0;
    while (!done && lat < 20) begin
      chk({tag, " busy_probe"}, int'(busy), 1);
      chk({tag, " cand_seq"}, int'(cand), lat);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    if (lat < 20) begin
      chk({tag, " busy_done"}, int'(busy), 1);
      chk({tag, " found"}, int'(found), exp_found);
      chk({tag, " result"}, int'(result), exp_result);
      chk({tag, " tries"}, int'(tries), exp_lat);
      chk({tag, " cand_final"}, int'(cand), exp_cand);
      @(negedge clk);
      chk({tag, " done_pulse_len"}, int'(done), 0);
      chk({tag, " busy_idle"}, int'(busy), 0);
    end
    $display("search %s: latency=%0d found=%0d result=%0d tries=%0d",
             tag, lat, found, result, tries);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    key  = v.key[WIDTH-1:0];
    kill = (v.kill != 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    probe_track(tag, v.exp_lat, v.exp_found, v.exp_result,
                (v.exp_found != 0) ? v.exp_result : 7);
    chk({tag, " tries_width"}, int'(tries), v.exp_tries);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{key: 5, kill: 0, exp_found: 1, exp_result: 5, exp_tries: 6, exp_lat: 6};
    vecs[1] = '{key: 0, kill: 0, exp_found: 1, exp_result: 0, exp_tries: 1, exp_lat: 1};
    vecs[2] = '{key: 7, kill: 0, exp_found: 1, exp_result: 7, exp_tries: 8, exp_lat: 8};
    vecs[3] = '{key: 3, kill: 1, exp_found: 0, exp_result: 0, exp_tries: 8, exp_lat: 8};
    vecs[4] = '{key: 1, kill: 0, exp_found: 1, exp_result: 1, exp_tries: 2, exp_lat: 2};

    // Reset state
    @(negedge clk);
    chk("rst cand", int'(cand), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst found", int'(found), 0);
    chk("rst result", int'(result), 0);
    chk("rst tries", int'(tries), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", int'(busy), 0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);
    kill = 1'b0;

    // start held through a whole search and its done cycle
    key = 3'd3;
    start = 1'b1;
    @(negedge clk);
    probe_track("held1", 4, 1, 3, 3);
    chk("held idle tries", int'(tries), 4);
    chk("held idle found", int'(found), 1);
    @(negedge clk);
    start = 1'b0;
    chk("held restart busy", int'(busy), 1);
    chk("held restart tries", int'(tries), 0);
    chk("held restart found", int'(found), 0);
    probe_track("held2", 4, 1, 3, 3);

    // Asynchronous abort mid-search
    key = 3'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("abort cand_before", int'(cand), 3);
    #2 rst = 1'b1;
    #1;
    chk("abort cand", int'(cand), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort tries", int'(tries), 0);
    chk("abort found", int'(found), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no_done", int'(done), 0);
      chk("abort stay_idle", int'(busy), 0);
    end
    run_vec("after_abort", '{key: 6, kill: 0, exp_found: 1, exp_result: 6, exp_tries: 7, exp_lat: 7});

    // Results hold after the key changes with no new start
    run_vec("hold", '{key: 2, kill: 0, exp_found: 1, exp_result: 2, exp_tries: 3, exp_lat: 3});
    key = 3'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold found", int'(found), 1);
      chk("hold result", int'(result), 2);
      chk("hold tries", int'(tries), 3);
      chk("hold busy", int'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
